// File: rtl/td4_pkg.sv
// Shared types for the td4_wide core: opcodes, datapath selects and FSM states.
// Pure declarations, no logic, so no latency or flow control applies here.
package td4_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A    = 4'b0000,
    OP_MOV_AB   = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_BA   = 4'b0100,
    OP_ADD_B    = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_JNZ      = 4'b1000,
    OP_OUT_B    = 4'b1001,
    OP_OUT_A    = 4'b1010,
    OP_OUT_IM   = 4'b1011,
    OP_HLT      = 4'b1100,
    OP_NOP      = 4'b1101,
    OP_JNC      = 4'b1110,
    OP_JMP      = 4'b1111
  } opcode_e;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_e;

  typedef enum logic [2:0] {
    DST_NONE = 3'd0,
    DST_A    = 3'd1,
    DST_B    = 3'd2,
    DST_OUT  = 3'd3,
    DST_PC   = 3'd4
  } dst_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

endpackage

// File: rtl/td4_wide_decoder.sv
// Combinational opcode decode to adder source, destination, jump decision and halt.
// Zero latency; no flow control, the caller qualifies outputs with its execute enable.
module td4_wide_decoder
  import td4_pkg::*;
(
  input  logic       i_carry,
  input  logic       i_zero,
  input  logic [3:0] i_instr,
  output logic [1:0] o_src_sel,
  output logic [2:0] o_dst,
  output logic       o_jump_taken,
  output logic       o_is_halt
);

  always_comb begin
    o_src_sel    = SRC_ZERO;
    o_dst        = DST_NONE;
    o_jump_taken = 1'b0;
    o_is_halt    = 1'b0;
    case (opcode_e'(i_instr))
      OP_ADD_A:    begin o_src_sel = SRC_A;    o_dst = DST_A;   end
      OP_ADD_B:    begin o_src_sel = SRC_B;    o_dst = DST_B;   end
      OP_MOV_A_IM: begin o_src_sel = SRC_ZERO; o_dst = DST_A;   end
      OP_MOV_B_IM: begin o_src_sel = SRC_ZERO; o_dst = DST_B;   end
      OP_MOV_AB:   begin o_src_sel = SRC_B;    o_dst = DST_A;   end
      OP_MOV_BA:   begin o_src_sel = SRC_A;    o_dst = DST_B;   end
      OP_IN_A:     begin o_src_sel = SRC_IN;   o_dst = DST_A;   end
      OP_IN_B:     begin o_src_sel = SRC_IN;   o_dst = DST_B;   end
      OP_OUT_B:    begin o_src_sel = SRC_B;    o_dst = DST_OUT; end
      OP_OUT_A:    begin o_src_sel = SRC_A;    o_dst = DST_OUT; end
      OP_OUT_IM:   begin o_src_sel = SRC_ZERO; o_dst = DST_OUT; end
      // Jumps add the immediate to zero; conditions use the flags before this instruction.
      OP_JMP:      begin o_dst = DST_PC; o_jump_taken = 1'b1;     end
      OP_JNC:      begin o_dst = DST_PC; o_jump_taken = ~i_carry; end
      OP_JNZ:      begin o_dst = DST_PC; o_jump_taken = ~i_zero;  end
      OP_HLT:      o_is_halt = 1'b1;
      default:     ;
    endcase
  end

endmodule

// File: rtl/td4_wide.sv
// Widened TD4 accumulator core: A/B/OUT registers, C/Z flags, PC, RUN/HALT FSM.
// Single-cycle execute; instr_valid low stalls all state, HALT freezes until reset.
module td4_wide
  import td4_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        instr,
  input  logic [DATA_W-1:0] imm,
  input  logic              instr_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              carry,
  output logic              zero
);

  if (ADDR_W > DATA_W) begin : g_bad_param
    $error("td4_wide: ADDR_W must not exceed DATA_W");
  end

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic [ADDR_W-1:0] r_pc;
  logic              r_c;
  logic              r_z;
  logic              r_out_valid;
  state_e            r_state;
  state_e            w_state_nxt;

  logic [1:0]        w_src_sel;
  logic [2:0]        w_dst;
  logic              w_jump;
  logic              w_is_halt;
  logic              w_exec;
  logic [DATA_W-1:0] w_src;
  logic [DATA_W:0]   w_sum;

  td4_wide_decoder u_dec (
    .i_carry      (r_c),
    .i_zero       (r_z),
    .i_instr      (instr),
    .o_src_sel    (w_src_sel),
    .o_dst        (w_dst),
    .o_jump_taken (w_jump),
    .o_is_halt    (w_is_halt)
  );

  assign w_exec = (r_state == RUN) && instr_valid;

  always_comb begin
    w_src = '0;
    case (w_src_sel)
      SRC_A:   w_src = r_a;
      SRC_B:   w_src = r_b;
      SRC_IN:  w_src = in_data;
      default: w_src = '0;
    endcase
  end

  assign w_sum = {1'b0, w_src} + {1'b0, imm};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_exec && w_is_halt) begin
      w_state_nxt = HALT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_pc        <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_exec && (w_dst == DST_OUT);
      if (w_exec) begin
        r_c <= w_sum[DATA_W];
        r_z <= (w_sum[DATA_W-1:0] == '0);
        case (w_dst)
          DST_A:   r_a   <= w_sum[DATA_W-1:0];
          DST_B:   r_b   <= w_sum[DATA_W-1:0];
          DST_OUT: r_out <= w_sum[DATA_W-1:0];
          default: ;
        endcase
        // HLT parks the PC on itself so the halted address stays observable.
        if (w_jump) begin
          r_pc <= w_sum[ADDR_W-1:0];
        end else if (!w_is_halt) begin
          r_pc <= r_pc + ADDR_W'(1);
        end
      end
    end
  end

  assign pc        = r_pc;
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign halted    = (r_state == HALT);
  assign carry     = r_c;
  assign zero      = r_z;

endmodule

// File: tb/tb_td4_wide.sv
// Directed bench for td4_wide: a 4-bit and an 8-bit-data instance driven from one vector table,
// plus hand-written HALT freeze and asynchronous reset sequences.
module tb_td4_wide;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0] i4_instr, o4_pc, i4_imm, i4_in, o4_out;
  logic       i4_vld, o4_ov, o4_h, o4_c, o4_z;

  logic [3:0] i8_instr, o8_pc;
  logic [7:0] i8_imm, i8_in, o8_out;
  logic       i8_vld, o8_ov, o8_h, o8_c, o8_z;

  td4_wide #(.DATA_W(4), .ADDR_W(4)) u4 (
    .clk(clk), .reset(reset), .instr(i4_instr), .imm(i4_imm), .instr_valid(i4_vld),
    .in_data(i4_in), .pc(o4_pc), .out_data(o4_out), .out_valid(o4_ov),
    .halted(o4_h), .carry(o4_c), .zero(o4_z)
  );

  td4_wide #(.DATA_W(8), .ADDR_W(4)) u8 (
    .clk(clk), .reset(reset), .instr(i8_instr), .imm(i8_imm), .instr_valid(i8_vld),
    .in_data(i8_in), .pc(o8_pc), .out_data(o8_out), .out_valid(o8_ov),
    .halted(o8_h), .carry(o8_c), .zero(o8_z)
  );

  typedef struct {
    logic       sel;
    logic [3:0] instr;
    logic [7:0] imm;
    logic       vld;
    logic [7:0] in;
    logic [3:0] pc;
    logic [7:0] out;
    logic       ov;
    logic       c;
    logic       z;
    logic       h;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Observed state packed as {pc, out, out_valid, carry, zero, halted}.
  function automatic logic [15:0] obs4();
    return {o4_pc, 4'h0, o4_out, o4_ov, o4_c, o4_z, o4_h};
  endfunction

  function automatic logic [15:0] obs8();
    return {o8_pc, o8_out, o8_ov, o8_c, o8_z, o8_h};
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {pc,out,ov,c,z,h}=%h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic sel, input logic [3:0] ins, input logic [7:0] imm,
                     input logic vld, input logic [7:0] din, input logic [3:0] pc,
                     input logic [7:0] out, input logic ov, input logic c,
                     input logic z, input logic h);
    vec_t v;
    v.sel = sel; v.instr = ins; v.imm = imm; v.vld = vld; v.in = din;
    v.pc = pc; v.out = out; v.ov = ov; v.c = c; v.z = z; v.h = h;
    vecs.push_back(v);
  endtask

  task automatic drive8(input logic [3:0] ins, input logic [7:0] imm, input logic vld,
                        input logic [7:0] din);
    i8_instr = ins; i8_imm = imm; i8_vld = vld; i8_in = din;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    if (v.sel) begin
      drive8(v.instr, v.imm, v.vld, v.in);
      i4_vld = 1'b0;
    end else begin
      i4_instr = v.instr; i4_imm = v.imm[3:0]; i4_vld = v.vld; i4_in = v.in[3:0];
      i8_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    check($sformatf("vec%0d", idx), v.sel ? obs8() : obs4(),
          {v.pc, v.out, v.ov, v.c, v.z, v.h});
  endtask

  initial begin
    reset = 1'b1;
    i4_instr = '0; i4_imm = '0; i4_vld = 1'b0; i4_in = '0;
    drive8(4'h0, 8'h00, 1'b0, 8'h00);

    // DATA_W=4: MOV/ADD/OUT A, pulse length, then IN B with carry and OUT B.
    add(0, 4'b0011, 8'h5, 1, 8'h0, 4'd1, 8'h0, 0, 0, 0, 0);
    add(0, 4'b0000, 8'h3, 1, 8'h0, 4'd2, 8'h0, 0, 0, 0, 0);
    add(0, 4'b1010, 8'h0, 1, 8'h0, 4'd3, 8'h8, 1, 0, 0, 0);
    add(0, 4'b1101, 8'h1, 1, 8'h0, 4'd4, 8'h8, 0, 0, 0, 0);
    add(0, 4'b0110, 8'h9, 1, 8'h9, 4'd5, 8'h8, 0, 1, 0, 0);
    add(0, 4'b1001, 8'h0, 1, 8'h0, 4'd6, 8'h2, 1, 0, 0, 0);
    // DATA_W=8, ADDR_W=4: overflow, conditional jumps, stalls, wrap, HLT.
    add(1, 4'b0011, 8'hFF, 1, 8'h00, 4'd1,  8'h00, 0, 0, 0, 0);
    add(1, 4'b0000, 8'h01, 1, 8'h00, 4'd2,  8'h00, 0, 1, 1, 0);
    add(1, 4'b1110, 8'h20, 1, 8'h00, 4'd3,  8'h00, 0, 0, 0, 0);
    add(1, 4'b0111, 8'h00, 1, 8'h00, 4'd4,  8'h00, 0, 0, 1, 0);
    add(1, 4'b1000, 8'h20, 1, 8'h00, 4'd5,  8'h00, 0, 0, 0, 0);
    add(1, 4'b1000, 8'h07, 1, 8'h00, 4'd7,  8'h00, 0, 0, 0, 0);
    add(1, 4'b1110, 8'h09, 1, 8'h00, 4'd9,  8'h00, 0, 0, 0, 0);
    add(1, 4'b1010, 8'h10, 1, 8'h00, 4'd10, 8'h10, 1, 0, 0, 0);
    add(1, 4'b1001, 8'h00, 1, 8'h00, 4'd11, 8'h00, 1, 0, 1, 0);
    add(1, 4'b1101, 8'h00, 1, 8'h00, 4'd12, 8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      add(1, 4'b1011, 8'h55, 0, 8'h00, 4'd12, 8'h00, 0, 0, 1, 0);
    add(1, 4'b1011, 8'h55, 1, 8'h00, 4'd13, 8'h55, 1, 0, 0, 0);
    add(1, 4'b0010, 8'h09, 1, 8'hF8, 4'd14, 8'h55, 0, 1, 0, 0);
    add(1, 4'b0000, 8'hFF, 1, 8'h00, 4'd15, 8'h55, 0, 1, 1, 0);
    add(1, 4'b1101, 8'h03, 1, 8'h00, 4'd0,  8'h55, 0, 0, 0, 0);
    add(1, 4'b1111, 8'h13, 1, 8'h00, 4'd3,  8'h55, 0, 0, 0, 0);
    add(1, 4'b1110, 8'h16, 1, 8'h00, 4'd6,  8'h55, 0, 0, 0, 0);
    add(1, 4'b1100, 8'h00, 1, 8'h00, 4'd6,  8'h55, 0, 0, 1, 1);

    #1;
    check("reset4", obs4(), 16'h0000);
    check("reset8", obs8(), 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // HALT ignores every input; state must hold at pc=6.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive8(4'($urandom), 8'($urandom), 1'b1, 8'($urandom));
      @(posedge clk);
      #1;
      check($sformatf("halt%0d", i), obs8(), {4'd6, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1});
    end

    // Asynchronous reset between edges, then an instruction presented under reset is discarded.
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst8", obs8(), 16'h0000);
    check("async_rst4", obs4(), 16'h0000);
    drive8(4'b1011, 8'h33, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("rst_discard", obs8(), 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    drive8(4'b1011, 8'h0A, 1'b1, 8'h00);
    @(posedge clk);
    #1;
    check("post_reset", obs8(), {4'd1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
